// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction cache fetch unit.
package icache_pkg;

  // Byte offset within a line; fixed by the controller's 64-bit fetch width.
  localparam int unsigned LINE_OFF_W = 3;

  typedef enum logic [1:0] {
    IC_IDLE      = 2'd0,
    IC_MISS      = 2'd1,
    IC_WAIT_DROP = 2'd2
  } ic_state_e;

  // Tag width left over from a 32-bit address after index and line offset.
  function automatic int unsigned tag_w(input int unsigned idx_w);
    return 32 - idx_w - LINE_OFF_W;
  endfunction

  // Pick one 32-bit instruction out of a little-endian 8-byte line.
  function automatic logic [31:0] sel_word(input logic [63:0] line, input logic word);
    return word ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/icache_fetch_unit_if.sv
// IF-side request/response and memory-controller line-fill signals.
interface icache_fetch_unit_if;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_ins;
  logic        mem_fetch_sig;
  logic [31:0] mem_fetch_addr;
  logic        mem_fetch_done;
  logic [63:0] mem_fetch_data;

  // Cache side.
  modport slave (
    input  if_req, if_pc, mem_fetch_done, mem_fetch_data,
    output if_valid, if_ins, mem_fetch_sig, mem_fetch_addr
  );

  // Environment side: IF stage plus memory controller.
  modport master (
    output if_req, if_pc, mem_fetch_done, mem_fetch_data,
    input  if_valid, if_ins, mem_fetch_sig, mem_fetch_addr
  );
endinterface

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: valid/tag/data arrays, combinational lookup, synchronous fill.
module icache_line_store #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [63:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [63:0]      wr_data
);
  localparam int unsigned Lines = 2 ** IDX_W;

  logic [Lines-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [Lines];
  logic [63:0]      data_q [Lines];

  // Valid bits are the only reset state; reset wins over a coincident fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Lookup at the requested index.
  always_comb begin
    hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_data = data_q[rd_idx];
  end
endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped I-cache: 1-cycle hits, 8-byte line fills from the memory controller.
module icache_fetch_unit
  import icache_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input logic                clk,
  input logic                rst,
  input logic                rdy,
  input logic                clear,
  icache_fetch_unit_if.slave bus
);
  localparam int unsigned TAG_W = tag_w(IDX_W);

  ic_state_e   state_q, state_d;
  logic [31:2] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_ins_q, if_ins_d;
  logic        sig_q, sig_d;
  logic [31:0] addr_q, addr_d;

  logic             hit;
  logic [63:0]      rd_data;
  logic             wr_en;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             unused_pc_bits;

  // Byte-within-word bits never matter for a 32-bit instruction fetch.
  assign unused_pc_bits = ^bus.if_pc[1:0];

  assign rd_idx = bus.if_pc[IDX_W+LINE_OFF_W-1:LINE_OFF_W];
  assign rd_tag = bus.if_pc[31:IDX_W+LINE_OFF_W];
  assign wr_idx = req_pc_q[IDX_W+LINE_OFF_W-1:LINE_OFF_W];
  assign wr_tag = req_pc_q[31:IDX_W+LINE_OFF_W];

  // Fill whenever done arrives in MISS, even alongside clear: the data is still correct.
  assign wr_en = rdy && (state_q == IC_MISS) && bus.mem_fetch_done;

  icache_line_store #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (rd_idx),
    .rd_tag  (rd_tag),
    .hit     (hit),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_tag  (wr_tag),
    .wr_data (bus.mem_fetch_data)
  );

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IC_IDLE;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_ins_q   <= '0;
      sig_q      <= 1'b0;
      addr_q     <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_ins_q   <= if_ins_d;
      sig_q      <= sig_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state: lookup in IDLE, wait for the fill in MISS, one dead cycle after it.
  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    if_valid_d = 1'b0;
    if_ins_d   = if_ins_q;
    sig_d      = sig_q;
    addr_d     = addr_q;
    unique case (state_q)
      IC_IDLE: begin
        // A request still high during the response pulse is the one just served.
        if (!clear && bus.if_req && !if_valid_q) begin
          if (hit) begin
            if_valid_d = 1'b1;
            if_ins_d   = sel_word(rd_data, bus.if_pc[2]);
          end else begin
            req_pc_d = bus.if_pc[31:2];
            sig_d    = 1'b1;
            addr_d   = {bus.if_pc[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            state_d  = IC_MISS;
          end
        end
      end
      IC_MISS: begin
        if (clear) begin
          sig_d   = 1'b0;
          addr_d  = '0;
          state_d = IC_IDLE;
        end else if (bus.mem_fetch_done) begin
          if_valid_d = 1'b1;
          if_ins_d   = sel_word(bus.mem_fetch_data, req_pc_q[2]);
          sig_d      = 1'b0;
          addr_d     = '0;
          state_d    = IC_WAIT_DROP;
        end
      end
      IC_WAIT_DROP: state_d = IC_IDLE;
      default:      state_d = IC_IDLE;
    endcase
  end

  // A stalled cycle never presents a response.
  always_comb begin
    bus.if_valid       = if_valid_q && rdy;
    bus.if_ins         = if_ins_q;
    bus.mem_fetch_sig  = sig_q;
    bus.mem_fetch_addr = addr_q;
  end
endmodule

// File: tb/tb_icache_fetch_unit.sv
// Self-checking bench: directed scenarios plus random fetches against a line-level cache model.
module tb_icache_fetch_unit;
  logic clk = 1'b0;
  logic rst, rdy, clear;
  icache_fetch_unit_if bus ();

  icache_fetch_unit #(.IDX_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 64 lines of valid/tag/data.
  bit          m_valid [64];
  bit [22:0]   m_tag   [64];
  bit [63:0]   m_data  [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] d, input logic w);
    return w ? d[63:32] : d[31:0];
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[8:3]] && (m_tag[pc[8:3]] == pc[31:9]);
  endfunction

  task automatic model_fill(input logic [31:0] pc, input logic [63:0] d);
    m_valid[pc[8:3]] = 1'b1;
    m_tag[pc[8:3]]   = pc[31:9];
    m_data[pc[8:3]]  = d;
  endtask

  // Full request: hit or miss as the model predicts, with optional controller latency and stall.
  task automatic fetch(input logic [31:0] pc, input logic [63:0] fill, input int lat,
                       input int stall);
    logic [31:0] line_addr;
    line_addr = {pc[31:3], 3'b000};
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    if (model_hit(pc)) begin
      step();
      check("hit_valid", bus.if_valid, 1);
      check("hit_ins", bus.if_ins, word_of(m_data[pc[8:3]], pc[2]));
      check("hit_nosig", bus.mem_fetch_sig, 0);
      bus.if_req = 1'b0;
      step();
      check("hit_pulse", bus.if_valid, 0);
    end else begin
      step();
      check("miss_valid0", bus.if_valid, 0);
      check("miss_sig", bus.mem_fetch_sig, 1);
      check("miss_addr", bus.mem_fetch_addr, line_addr);
      for (int i = 0; i < lat; i++) begin
        step();
        check("miss_hold", {bus.mem_fetch_sig, bus.mem_fetch_addr}, {1'b1, line_addr});
      end
      if (stall > 0) begin
        rdy = 1'b0;
        for (int i = 0; i < stall; i++) begin
          step();
          check("stall_hold", {bus.if_valid, bus.mem_fetch_sig, bus.mem_fetch_addr},
                {1'b0, 1'b1, line_addr});
        end
        rdy = 1'b1;
      end
      bus.mem_fetch_done = 1'b1;
      bus.mem_fetch_data = fill;
      step();
      check("fill_valid", bus.if_valid, 1);
      check("fill_ins", bus.if_ins, word_of(fill, pc[2]));
      check("fill_sig", {bus.mem_fetch_sig, bus.mem_fetch_addr}, 33'd0);
      if (stall > 0) begin
        rdy = 1'b0;
        #1;
        check("stall_gate", bus.if_valid, 0);
        rdy = 1'b1;
      end
      bus.mem_fetch_done = 1'b0;
      bus.if_req         = 1'b0;
      model_fill(pc, fill);
      step();
      check("drop_valid", bus.if_valid, 0);
    end
  endtask

  // Miss aborted by clear before the controller answers.
  task automatic flush_miss(input logic [31:0] pc, input int lat);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    step();
    check("fl_sig", bus.mem_fetch_sig, 1);
    repeat (lat) step();
    clear      = 1'b1;
    bus.if_req = 1'b0;
    step();
    check("fl_drop", {bus.if_valid, bus.mem_fetch_sig, bus.mem_fetch_addr}, 34'd0);
    clear = 1'b0;
    step();
    check("fl_novalid", bus.if_valid, 0);
  endtask

  // clear arriving with done: line is filled but nothing is returned.
  task automatic clear_done(input logic [31:0] pc, input logic [63:0] fill);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    step();
    check("cd_sig", bus.mem_fetch_sig, 1);
    step();
    bus.mem_fetch_done = 1'b1;
    bus.mem_fetch_data = fill;
    clear              = 1'b1;
    bus.if_req         = 1'b0;
    step();
    check("cd_novalid", {bus.if_valid, bus.mem_fetch_sig}, 2'b00);
    bus.mem_fetch_done = 1'b0;
    clear              = 1'b0;
    model_fill(pc, fill);
    step();
    check("cd_idle", bus.if_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [63:0] d;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    bus.if_req = 1'b0; bus.if_pc = '0;
    bus.mem_fetch_done = 1'b0; bus.mem_fetch_data = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_state", {bus.if_valid, bus.if_ins, bus.mem_fetch_sig, bus.mem_fetch_addr}, '0);

    // Cold miss, same-line hit, conflict eviction.
    fetch(32'h0, 64'h11223344_55667788, 2, 0);
    fetch(32'h4, 64'h0, 0, 0);
    fetch(32'h200, 64'hAAAA0001_BBBB0002, 1, 0);
    fetch(32'h0, 64'h11223344_55667788, 0, 0);

    // Flush mid-miss, then clear coincident with done, then a hit on the filled line.
    flush_miss(32'h10, 2);
    clear_done(32'h10, 64'hCAFEF00D_DEADBEEF);
    fetch(32'h10, 64'h0, 0, 0);

    // Stall during a miss.
    fetch(32'h38, 64'h01020304_05060708, 1, 3);

    // clear in IDLE suppresses an otherwise hitting request.
    bus.if_req = 1'b1; bus.if_pc = 32'h14; clear = 1'b1;
    step();
    check("idle_clear", bus.if_valid, 0);
    clear = 1'b0; bus.if_req = 1'b0;
    step();

    // Top index.
    fetch(32'h1F8, 64'h76543210_FEDCBA98, 0, 0);
    fetch(32'h1FC, 64'h0, 0, 0);

    // Reset in the middle of a miss invalidates everything.
    bus.if_req = 1'b1; bus.if_pc = 32'h80;
    step();
    check("rm_sig", bus.mem_fetch_sig, 1);
    rst = 1'b1; bus.if_req = 1'b0;
    step();
    rst = 1'b0;
    check("rm_clear", {bus.mem_fetch_sig, bus.mem_fetch_addr}, 33'd0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    fetch(32'h0, 64'h99887766_55443322, 0, 0);

    // Random traffic over a few tags and indices, including the top index.
    for (int n = 0; n < 80; n++) begin
      pc = {$urandom_range(0, 3)} << 9;
      pc = pc | (($urandom_range(0, 3) == 0 ? 32'd63 : 32'($urandom_range(0, 7))) << 3);
      pc = pc | (32'($urandom_range(0, 7)));
      d  = {$urandom, $urandom};
      fetch(pc, d, $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
